// File: rtl/bus_initiator.sv
// Femto bus initiator: one command in, one single-cycle req out, one
// completion record back with OK / fault / timeout / misaligned status.
module bus_initiator #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_w_rb,
  input  logic [1:0]    cmd_acc,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_status,
  output logic [AW-1:0] addr,
  output logic          w_rb,
  output logic [1:0]    acc,
  output logic [DW-1:0] wdata,
  output logic          req,
  input  logic [DW-1:0] rdata,
  input  logic          resp,
  input  logic          fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;
  localparam logic [1:0] ST_ALIGN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          w_rb_q, w_rb_d;
  logic [1:0]    acc_q, acc_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    status_q, status_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_cmd;

  function automatic logic [DW-1:0] acc_mask(input logic [1:0] a);
    case (a)
      2'd0:    return DW'(8'hFF);
      2'd1:    return DW'(16'hFFFF);
      default: return '1;
    endcase
  endfunction

  // Reads return data trimmed to the access width; writes report zero.
  function automatic logic [DW-1:0] rd_val(input logic wr,
                                           input logic [1:0] a,
                                           input logic [DW-1:0] d);
    return wr ? '0 : (d & acc_mask(a));
  endfunction

  assign bad_cmd = (cmd_acc == 2'd3)
                 || (cmd_acc == 2'd1 && cmd_addr[0])
                 || (cmd_acc == 2'd2 && cmd_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      w_rb_q   <= 1'b0;
      acc_q    <= 2'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      w_rb_q   <= w_rb_d;
      acc_q    <= acc_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    w_rb_d   = w_rb_q;
    acc_d    = acc_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (bad_cmd) begin
            state_d  = S_DONE;
            status_d = ST_ALIGN;
            rdata_d  = '0;
          end else begin
            state_d = S_ISSUE;
            addr_d  = cmd_addr;
            w_rb_d  = cmd_w_rb;
            acc_d   = cmd_acc;
            wdata_d = cmd_wdata & acc_mask(cmd_acc);
          end
        end
      end
      S_ISSUE: begin
        if (fault) begin
          state_d  = S_DONE;
          status_d = ST_FAULT;
          rdata_d  = '0;
        end else if (resp) begin
          state_d  = S_DONE;
          status_d = ST_OK;
          rdata_d  = rd_val(w_rb_q, acc_q, rdata);
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (resp) begin
          state_d  = S_DONE;
          status_d = ST_OK;
          rdata_d  = rd_val(w_rb_q, acc_q, rdata);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_DONE;
          status_d = ST_TMO;
          rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    req       = (state_q == S_ISSUE);
    rsp_valid = (state_q == S_DONE);
  end

  assign addr       = addr_q;
  assign w_rb       = w_rb_q;
  assign acc        = acc_q;
  assign wdata      = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with TIMEOUT=8 and a hand-driven
// responder; each task checks its own scenario inline.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_w_rb;
  logic [1:0]  cmd_acc;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] wdata;
  logic        req;
  logic [31:0] rdata;
  logic        resp;
  logic        fault;

  int checks = 0;
  int failures = 0;

  bus_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_w_rb(cmd_w_rb),
    .cmd_acc(cmd_acc), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
    .req(req), .rdata(rdata), .resp(resp), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic wr,
                      input logic [1:0] ac, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_w_rb  = wr;
    cmd_acc   = ac;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req, rsp_valid, w_rb, acc, rsp_status} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0",
               {req, rsp_valid, w_rb, acc, rsp_status});
    end
    checks++;
    if ({addr, wdata, rsp_rdata} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {addr, wdata, rsp_rdata});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write_1b();
    send(32'h0, 1'b1, 2'd0, 32'hFFFF_FF03);
    checks++;
    if ({req, cmd_ready} !== 2'b10) begin
      failures++;
      $display("FAIL wr_req got=%b exp=10", {req, cmd_ready});
    end
    checks++;
    if ({wdata, acc, w_rb} !== {32'h3, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL wr_bus got=%h exp=%h", {wdata, acc, w_rb},
               {32'h3, 2'd0, 1'b1});
    end
    tick();
    checks++;
    if ({req, rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL wr_pulse got=%b exp=00", {req, rsp_valid});
    end
    resp = 1'b1;
    tick();
    resp = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL wr_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd0, 32'h0});
    end
    consume();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL wr_idle got=%b exp=10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_reads();
    send(32'h10, 1'b0, 2'd2, 32'h0);
    tick();
    repeat (5) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd4_early got=%b exp=0", rsp_valid);
    end
    resp  = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    resp  = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL rd4_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd0, 32'hDEAD_BEEF});
    end
    consume();
    send(32'h22, 1'b0, 2'd1, 32'h0);
    tick();
    resp = 1'b1;
    tick();
    resp = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd0, 32'h0000_BEEF}) begin
      failures++;
      $display("FAIL rd2_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd0, 32'h0000_BEEF});
    end
    consume();
  endtask

  task automatic test_fault();
    send(32'h30, 1'b0, 2'd2, 32'h0);
    fault = 1'b1;
    resp  = 1'b1;
    tick();
    fault = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd1, 32'h0}) begin
      failures++;
      $display("FAIL flt_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd1, 32'h0});
    end
    tick();
    resp = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL flt_hold got=%b exp=101", {rsp_valid, rsp_status});
    end
    consume();
    resp = 1'b1;
    tick();
    resp = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, req} !== 3'b100) begin
      failures++;
      $display("FAIL flt_stray got=%b exp=100", {cmd_ready, rsp_valid, req});
    end
  endtask

  task automatic test_timeout();
    send(32'h40, 1'b0, 2'd2, 32'h0);
    tick();
    repeat (3) tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got=%b exp=0", rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd2, 32'h0}) begin
      failures++;
      $display("FAIL tmo_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd2, 32'h0});
    end
    consume();
    send(32'h44, 1'b0, 2'd2, 32'h0);
    tick();
    repeat (7) tick();
    resp  = 1'b1;
    rdata = 32'h1234_5678;
    tick();
    resp  = 1'b0;
    checks++;
    if ({rsp_valid, rsp_status, rsp_rdata} !== {1'b1, 2'd0, 32'h1234_5678}) begin
      failures++;
      $display("FAIL tmo_edge got=%h exp=%h", {rsp_valid, rsp_status, rsp_rdata},
               {1'b1, 2'd0, 32'h1234_5678});
    end
    consume();
  endtask

  task automatic test_misaligned();
    send(32'h2, 1'b0, 2'd2, 32'h0);
    checks++;
    if ({req, rsp_valid, rsp_status, rsp_rdata} !== {1'b0, 1'b1, 2'd3, 32'h0}) begin
      failures++;
      $display("FAIL mis4 got=%h exp=%h", {req, rsp_valid, rsp_status, rsp_rdata},
               {1'b0, 1'b1, 2'd3, 32'h0});
    end
    consume();
    checks++;
    if (req !== 1'b0) begin
      failures++;
      $display("FAIL mis4_noreq got=%b exp=0", req);
    end
    send(32'h0, 1'b1, 2'd3, 32'hFFFF_FFFF);
    checks++;
    if ({req, rsp_valid, rsp_status} !== {1'b0, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL acc3 got=%b exp=%b", {req, rsp_valid, rsp_status},
               {1'b0, 1'b1, 2'd3});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send(32'h50, 1'b1, 2'd2, 32'hA5A5_A5A5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({addr, wdata, rsp_rdata} !== 96'b0) begin
      failures++;
      $display("FAIL rstmid_data got=%h exp=0", {addr, wdata, rsp_rdata});
    end
    resp = 1'b1;
    tick();
    resp = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, req, w_rb} !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_ctl got=%b exp=1000", {cmd_ready, rsp_valid, req, w_rb});
    end
  endtask

  task automatic test_done_hold();
    send(32'h60, 1'b0, 2'd2, 32'h0);
    resp  = 1'b1;
    rdata = 32'hCAFE_F00D;
    tick();
    resp  = 1'b0;
    rdata = 32'h0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h64;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_status, rsp_rdata} !==
          {1'b1, 1'b0, 2'd0, 32'hCAFE_F00D}) begin
        failures++;
        $display("FAIL hold[%0d] got=%h exp=%h", i,
                 {rsp_valid, cmd_ready, rsp_status, rsp_rdata},
                 {1'b1, 1'b0, 2'd0, 32'hCAFE_F00D});
      end
      tick();
    end
    cmd_valid = 1'b0;
    consume();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release got=%b exp=10", {cmd_ready, rsp_valid});
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_w_rb  = 1'b0;
    cmd_acc   = 2'd0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    rdata = '0;
    resp  = 1'b0;
    fault = 1'b0;
    test_reset();
    test_write_1b();
    test_reads();
    test_fault();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_done_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Command-driven initiator (master) for the femto peripheral bus (addr/w_rb/acc/wdata/req → rdata/resp/fault).
- Accepts one transfer command at a time and issues a single-cycle req.
- Waits for resp or fault, bounded by a timeout watchdog, then returns a completion record with status.
- Sits between debug/DMA-style sources and peripheral responders such as the reset controller.

Parameters:
- AW, 32, bus address width.
- DW, 32, bus data width (matches `BUS_WIDTH).
- TIMEOUT, 255, maximum cycles waited for resp after req; minimum 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AW  target address.
- cmd_w_rb  in  1  1=write, 0=read.
- cmd_acc  in  2  access size: 0=1B, 1=2B, 2=4B, 3=illegal (`BUS_ACC_* encoding).
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  completion record valid.
- rsp_ready  in  1  completion consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DW  read data, zero-extended to access width; 0 for writes and errors.
- rsp_status  out  2  0=OK, 1=bus fault, 2=timeout, 3=misaligned/illegal acc.
- addr  out  AW  bus address.
- w_rb  out  1  bus direction.
- acc  out  2  bus access size.
- wdata  out  DW  bus write data, masked to access width (upper bits 0).
- req  out  1  bus request, single-cycle pulse.
- rdata  in  DW  bus read data, valid with resp.
- resp  in  1  bus completion.
- fault  in  1  bus error, combinational, valid in the req cycle only.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; req, rsp_valid = 0; addr, wdata, rsp_rdata = 0; w_rb = 0; acc = 0; rsp_status = 0; timeout counter = 0.
  - cmd_ready is 1 in the first post-reset cycle.
  - rst mid-transfer abandons it; no rsp is produced, and a late resp is ignored.
- State machine:
  - IDLE: cmd_ready=1.
    - On accept, if cmd_acc=3, or addr not aligned to the size (2B: addr[0]≠0; 4B: addr[1:0]≠0): go to DONE, status=3, rdata=0, no req issued.
    - Otherwise register addr/w_rb/acc/masked wdata and go to ISSUE.
  - ISSUE (exactly 1 cycle): req=1; bus outputs stable.
    - fault=1: go to DONE, status=1 (fault has priority over resp).
    - Else resp=1: go to DONE, status=0, capture rdata.
    - Else go to WAIT with counter cleared.
  - WAIT: req=0; bus outputs held; counter increments each cycle.
    - resp=1: go to DONE, status=0, capture rdata (masked, zero for writes).
    - Else counter reaches TIMEOUT-1: go to DONE, status=2.
    - resp in the same cycle as expiry: resp wins, status 0.
    - fault in WAIT is ignored.
  - DONE: rsp_valid=1, rsp fields held stable.
    - rsp_ready=1: go to IDLE.
    - No new command is accepted in DONE; cmd_ready=0 outside IDLE.
- Latency:
  - Command accept to req: 1 cycle.
  - Zero-wait responder (resp one cycle after req): rsp_valid 2 cycles after req.
  - Throughput: at most one transfer per 4 cycles with rsp_ready tied high.
- Stray resp/fault in IDLE or DONE: ignored; no state change.
- Timeout: exactly TIMEOUT cycles in WAIT without resp yields status 2.
- Counter width: clog2(TIMEOUT+1); no wrap.

Test Plan:
- 1B write addr=0x0, wdata=0xFFFFFF03, responder resp 1 cycle after req → bus shows req for one cycle, wdata=0x03, acc=0; rsp_valid 2 cycles after req, status=0, rdata=0.
- 4B read addr=0x10, responder returns rdata=0xDEADBEEF after 5 wait cycles → status=0, rsp_rdata=0xDEADBEEF; 2B read returning 0xDEADBEEF → rsp_rdata=0x0000BEEF.
- Responder asserts fault in req cycle (read of write-only reg) → status=1, no wait; a resp arriving next cycle is ignored and does not start a new rsp.
- No resp, TIMEOUT=8 → status=2 after exactly 8 WAIT cycles; separately, resp on the expiry cycle → status=0.
- 4B access addr=0x2, and acc=3 addr=0x0 → status=3 one cycle after accept, req never asserted.
- rst during WAIT, then resp → all outputs at reset values, no rsp_valid; rsp_ready held low in DONE for 10 cycles → rsp fields stable, cmd_ready=0 throughout.
